// File: rtl/mem_fill_arbiter.sv
// Cache line fill arbiter: serves I/D cache misses (D first) by reading a
// 4-word line from main memory one word at a time and strobing it into the cache.
module mem_fill_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        imiss,
   input  logic [31:0] imiss_addr,
   input  logic        dmiss,
   input  logic [31:0] dmiss_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic [31:0] fill_data,
   output logic [1:0]  fill_word,
   output logic        fill_we_i,
   output logic        fill_we_d,
   output logic        ifill,
   output logic        dfill,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL_I = 3'd1,
      FILL_D = 3'd2,
      DONE_I = 3'd3,
      DONE_D = 3'd4,
      HOLD   = 3'd5
   } state_t;

   state_t      state, state_next;
   logic [27:0] line;
   logic [1:0]  cnt;
   logic        filling;

   // Byte offset bits of the miss addresses are irrelevant to a line fill.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{imiss_addr[3:0], dmiss_addr[3:0]};

   assign filling = (state == FILL_I) || (state == FILL_D);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (dmiss)      state_next = FILL_D;
            else if (imiss) state_next = FILL_I;
         end
         FILL_I:  if (mem_valid && cnt == 2'd3) state_next = DONE_I;
         FILL_D:  if (mem_valid && cnt == 2'd3) state_next = DONE_D;
         DONE_I:  state_next = HOLD;
         DONE_D:  state_next = HOLD;
         HOLD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req = filling;
      ifill   = (state == DONE_I);
      dfill   = (state == DONE_D);
      busy    = (state != IDLE);
   end

   assign mem_addr = {line, cnt, 2'b00};

   // Line address is captured only in IDLE, so requester address changes
   // during a fill never disturb the word sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         line      <= '0;
         cnt       <= '0;
         fill_data <= '0;
         fill_word <= '0;
         fill_we_i <= 1'b0;
         fill_we_d <= 1'b0;
      end else begin
         fill_we_i <= 1'b0;
         fill_we_d <= 1'b0;
         case (state)
            IDLE: begin
               if (dmiss) begin
                  line <= dmiss_addr[31:4];
                  cnt  <= 2'd0;
               end else if (imiss) begin
                  line <= imiss_addr[31:4];
                  cnt  <= 2'd0;
               end
            end
            FILL_I, FILL_D: begin
               if (mem_valid) begin
                  fill_data <= mem_rdata;
                  fill_word <= cnt;
                  fill_we_i <= (state == FILL_I);
                  fill_we_d <= (state == FILL_D);
                  cnt       <= cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: directed scenarios plus random
// fills, checked every cycle against address/data expectations built from the line rules.
module tb_mem_fill_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imiss, dmiss, mem_valid;
   logic [31:0] imiss_addr, dmiss_addr, mem_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] fill_data;
   logic [1:0]  fill_word;
   logic        fill_we_i, fill_we_d, ifill, dfill, busy;

   int checks   = 0;
   int failures = 0;

   mem_fill_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .imiss      (imiss),
      .imiss_addr (imiss_addr),
      .dmiss      (dmiss),
      .dmiss_addr (dmiss_addr),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_valid  (mem_valid),
      .fill_data  (fill_data),
      .fill_word  (fill_word),
      .fill_we_i  (fill_we_i),
      .fill_we_d  (fill_we_d),
      .ifill      (ifill),
      .dfill      (dfill),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference: word w of the line holding byte address a.
   function automatic logic [31:0] word_addr(input logic [31:0] a, input int w);
      return (a / 16) * 16 + 32'(4 * w);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"},   mem_req,   0);
      check({tag, "_mem_addr"},  mem_addr,  0);
      check({tag, "_fill_data"}, fill_data, 0);
      check({tag, "_fill_word"}, fill_word, 0);
      check({tag, "_we"},        {fill_we_i, fill_we_d}, 0);
      check({tag, "_pulses"},    {ifill, dfill}, 0);
      check({tag, "_busy"},      busy,      0);
   endtask

   // Entered one cycle after the miss was seen in IDLE (DUT in FILL_x).
   // Serves nwords words with random gaps; for a full line also walks DONE,
   // HOLD and back to IDLE.
   task automatic serve_line(input bit is_d, input logic [31:0] addr, input int gmin,
                             input int gmax, input bit jitter, input bit spurious,
                             input int nwords);
      logic [31:0] data;
      int          gap;
      data = '0;
      for (int w = 0; w < nwords; w++) begin
         gap = int'($urandom_range(gmax, gmin));
         for (int g = 0; g <= gap; g++) begin
            check("fill_mem_req",  mem_req,  1);
            check("fill_mem_addr", mem_addr, word_addr(addr, w));
            check("fill_busy",     busy,     1);
            if (g < gap) begin
               mem_valid = 1'b0;
               mem_rdata = $urandom;
               if (jitter && is_d)  dmiss_addr = $urandom;
               if (jitter && !is_d) imiss_addr = $urandom;
               step;
               check("gap_we", {fill_we_i, fill_we_d}, 0);
            end
         end
         data      = $urandom;
         mem_rdata = data;
         mem_valid = 1'b1;
         if (jitter && is_d)  dmiss_addr = $urandom;
         if (jitter && !is_d) imiss_addr = $urandom;
         step;
         mem_valid = 1'b0;
         check("we_served", is_d ? fill_we_d : fill_we_i, 1);
         check("we_other",  is_d ? fill_we_i : fill_we_d, 0);
         check("fill_word", fill_word, w);
         check("fill_data", fill_data, data);
         if (w < 3) check("pulses_mid", {ifill, dfill}, 0);
      end
      if (nwords == 4) begin
         check("done_ifill",   ifill,   !is_d);
         check("done_dfill",   dfill,   is_d);
         check("done_mem_req", mem_req, 0);
         check("done_busy",    busy,    1);
         if (is_d) dmiss = 1'b0;
         else      imiss = 1'b0;
         mem_valid = spurious;
         mem_rdata = $urandom;
         step;
         check("hold_busy",   busy,    1);
         check("hold_pulses", {ifill, dfill}, 0);
         check("hold_we",     {fill_we_i, fill_we_d}, 0);
         check("hold_req",    mem_req, 0);
         mem_valid = spurious;
         mem_rdata = $urandom;
         step;
         mem_valid = 1'b0;
         check("idle_busy",      busy,      0);
         check("idle_we",        {fill_we_i, fill_we_d}, 0);
         check("idle_mem_addr",  mem_addr,  word_addr(addr, 0));
         check("idle_fill_data", fill_data, data);
      end
   endtask

   initial begin
      logic [31:0] a, held;
      bit          d;
      rst = 1'b1; imiss = 1'b0; dmiss = 1'b0; mem_valid = 1'b0;
      imiss_addr = '0; dmiss_addr = '0; mem_rdata = '0;
      step; step;
      rst = 1'b0;
      check_all_zero("reset");
      step;
      check("idle_after_reset_busy", busy, 0);

      // I miss at 0x1234, memory answers every cycle.
      imiss_addr = 32'h0000_1234; imiss = 1'b1;
      step;
      serve_line(1'b0, 32'h0000_1234, 0, 0, 1'b0, 1'b0, 4);

      // Simultaneous misses: D line first, then I line after HOLD.
      dmiss_addr = 32'h0000_2000; imiss_addr = 32'h0000_3008;
      dmiss = 1'b1; imiss = 1'b1;
      step;
      serve_line(1'b1, 32'h0000_2000, 0, 0, 1'b1, 1'b0, 4);
      step;
      serve_line(1'b0, 32'h0000_3008, 0, 0, 1'b0, 1'b0, 4);

      // D miss with memory answering 3 cycles late on every word.
      dmiss_addr = 32'h8765_4328; dmiss = 1'b1;
      step;
      serve_line(1'b1, 32'h8765_4328, 3, 3, 1'b0, 1'b1, 4);

      // Reset after the second word of an I fill; held miss restarts at word 0.
      imiss_addr = 32'h0040_0A5C; imiss = 1'b1;
      step;
      serve_line(1'b0, 32'h0040_0A5C, 0, 1, 1'b0, 1'b0, 2);
      rst = 1'b1;
      step;
      rst = 1'b0;
      check_all_zero("abort");
      step;
      serve_line(1'b0, 32'h0040_0A5C, 0, 2, 1'b0, 1'b0, 4);

      // Spurious mem_valid while IDLE.
      held = word_addr(32'h0040_0A5C, 0);
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1'b1;
         mem_rdata = $urandom;
         step;
         check("spur_idle_we",   {fill_we_i, fill_we_d}, 0);
         check("spur_idle_busy", busy, 0);
         check("spur_idle_addr", mem_addr, held);
      end
      mem_valid = 1'b0;

      // Random fills with address jitter and spurious valids in HOLD.
      for (int i = 0; i < 8; i++) begin
         d = 1'($urandom_range(1, 0));
         a = $urandom;
         if (d) begin dmiss_addr = a; dmiss = 1'b1; end
         else   begin imiss_addr = a; imiss = 1'b1; end
         step;
         serve_line(d, a, 0, 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
